// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative signed multiplier.
// Holds state encoding, magnitude and saturating-shift functions.
package seq_mult_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [MAX_W-1:0] q;
    } sat_res_t;

    // Two's-complement magnitude; the most-negative value maps to 2^(W-1).
    function automatic logic [MAX_W-1:0] abs_u(input logic signed [MAX_W-1:0] x);
        logic [MAX_W-1:0] ux;
        ux = x;
        return x[MAX_W-1] ? (~ux + MAX_W'(1)) : ux;
    endfunction

    function automatic sat_res_t sat_shift(
        input logic signed [2*MAX_W-1:0] p,
        input int                        frac,
        input int                        w
    );
        logic signed [2*MAX_W-1:0] one;
        logic signed [2*MAX_W-1:0] sh;
        logic signed [2*MAX_W-1:0] hi;
        logic signed [2*MAX_W-1:0] lo;
        sat_res_t                  r;
        one = 1;
        sh  = p >>> frac;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        r.sat = 1'b0;
        r.q   = sh[MAX_W-1:0];
        if (sh > hi) begin
            r.sat = 1'b1;
            r.q   = hi[MAX_W-1:0];
        end else if (sh < lo) begin
            r.sat = 1'b1;
            r.q   = lo[MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned radix-2^BITS_PER_CYCLE shift-and-add datapath.
// Exposes the next accumulator value so the caller can register the final sum.
module seq_mult_core
    import seq_mult_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   mcand,
    input  logic [DATA_WIDTH-1:0]   mplier,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] acc_next
);

    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DATA_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
        $error("BITS_PER_CYCLE must divide DATA_WIDTH");
    end

    logic [PW-1:0]             acc;
    logic [PW-1:0]             mc_sh;
    logic [DATA_WIDTH-1:0]     sr;
    logic [CW-1:0]             count;
    logic                      run;
    logic [BITS_PER_CYCLE-1:0] digit;

    assign digit    = sr[BITS_PER_CYCLE-1:0];
    assign acc_next = acc + (mc_sh * PW'(digit));
    assign done     = run && (count == CW'(N - 1));

    // Multiplicand moves left as multiplier digits are retired LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mc_sh <= '0;
            sr    <= '0;
            count <= '0;
            run   <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            mc_sh <= PW'(mcand);
            sr    <= mplier;
            count <= '0;
            run   <= 1'b1;
        end else if (run) begin
            acc   <= acc_next;
            mc_sh <= mc_sh << BITS_PER_CYCLE;
            sr    <= sr >> BITS_PER_CYCLE;
            if (done) begin
                run   <= 1'b0;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_signed_mult.sv
// Iterative signed multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_SAT_EN to add the shifted, saturated dout_q/sat outputs.
module seq_signed_mult
    import seq_mult_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int FRAC_BITS      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   din1,
    input  logic [DATA_WIDTH-1:0]   din2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] dout,
`ifdef SEQ_MULT_SAT_EN
    output logic [DATA_WIDTH-1:0]   dout_q,
    output logic                    sat,
`endif
    output logic                    busy
);

    localparam int PW = 2 * DATA_WIDTH;

    if (DATA_WIDTH > MAX_W) begin : g_bad_width
        $error("DATA_WIDTH exceeds MAX_W");
    end
    if (FRAC_BITS < 0 || FRAC_BITS >= PW) begin : g_bad_frac
        $error("FRAC_BITS out of range");
    end

    state_t                state;
    state_t                next;
    logic                  load;
    logic                  core_done;
    logic                  sign_r;
    logic                  zero_r;
    logic [DATA_WIDTH-1:0] mag1;
    logic [DATA_WIDTH-1:0] mag2;
    logic [PW-1:0]         acc_next;
    logic [PW-1:0]         prod;
    logic                  finish;

    assign mag1   = DATA_WIDTH'(abs_u(MAX_W'(signed'(din1))));
    assign mag2   = DATA_WIDTH'(abs_u(MAX_W'(signed'(din2))));
    assign prod   = zero_r ? '0 : (sign_r ? -acc_next : acc_next);
    assign finish = (state == CALC) && core_done;

    seq_mult_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (load),
        .mcand   (mag1),
        .mplier  (mag2),
        .done    (core_done),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // In DONE, ready passes through so a new pair can load on the drain edge.
    always_comb begin
        next      = state;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    load = 1'b1;
                    next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (core_done) next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                        next = CALC;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            zero_r <= 1'b0;
        end else if (load) begin
            sign_r <= din1[DATA_WIDTH-1] ^ din2[DATA_WIDTH-1];
            zero_r <= (din1 == '0) || (din2 == '0);
        end
    end

`ifdef SEQ_MULT_SAT_EN
    sat_res_t sres;

    assign sres = sat_shift((2*MAX_W)'(signed'(prod)), FRAC_BITS, DATA_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            dout_q <= '0;
            sat    <= 1'b0;
        end else if (finish) begin
            dout   <= prod;
            dout_q <= DATA_WIDTH'(sres.q);
            sat    <= sres.sat;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout <= '0;
        else if (finish) dout <= prod;
    end
`endif

endmodule

// File: tb/tb_seq_signed_mult.sv
// Scoreboard bench for seq_signed_mult at DATA_WIDTH=8, BITS_PER_CYCLE=2.
// Saturation checks are built in when SEQ_MULT_SAT_EN is defined.
module tb_seq_signed_mult;

    localparam int W = 8;
    localparam int B = 2;
    localparam int N = W / B;
    localparam int F = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [W-1:0]   din1 = '0;
    logic [W-1:0]   din2 = '0;
    logic [2*W-1:0] dout;
    logic [2*W-1:0] exp_q[$];
    int             passed = 0;
    int             total = 0;
`ifdef SEQ_MULT_SAT_EN
    logic [W-1:0]   dout_q;
    logic           sat;
    logic [W:0]     sat_q[$];
`endif

    always #5 clk = ~clk;

    seq_signed_mult #(
        .DATA_WIDTH    (W),
        .BITS_PER_CYCLE(B),
        .FRAC_BITS     (F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din1     (din1),
        .din2     (din2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
`ifdef SEQ_MULT_SAT_EN
        .dout_q   (dout_q),
        .sat      (sat),
`endif
        .busy     (busy)
    );

    task automatic push_exp(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
`ifdef SEQ_MULT_SAT_EN
        int q;
        logic s;
`endif
        p = a * b;
        exp_q.push_back(p);
`ifdef SEQ_MULT_SAT_EN
        q = int'(p) >>> F;
        s = 1'b0;
        if (q > 127) begin q = 127; s = 1'b1; end
        if (q < -128) begin q = -128; s = 1'b1; end
        sat_q.push_back({s, q[W-1:0]});
`endif
    endtask

    // Drives one pair, waits for acceptance, returns on the negedge after it.
    task automatic issue(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int n;
        din1 = a;
        din2 = b;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        push_exp(a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        din1 = W'($urandom);
        din2 = W'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [2*W-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000)
            $display("FAIL reset_flags: rdy/vld/busy=%b required 000", {in_ready, out_valid, busy});
        else passed++;
        total++;
        if (dout !== '0) $display("FAIL reset_dout: got %h required 0000", dout);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] e;
        issue(-8'sd3, 8'sd5);
        total++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL basic_busy: busy/rdy=%b required 10", {busy, in_ready});
        else passed++;
        wait_out(lat);
        total++;
        if (lat !== N) $display("FAIL basic_latency: got %0d required %0d", lat, N);
        else passed++;
        e = pop_exp();
        total++;
        if (dout !== e) $display("FAIL basic_dout: got %h required %h", dout, e);
        else passed++;
        drain();
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_idle: vld/rdy=%b required 01", {out_valid, in_ready});
        else passed++;
    endtask

    task automatic test_extremes();
        logic signed [W-1:0] av[4] = '{-8'sd128, 8'sd127, -8'sd128, 8'sd127};
        logic signed [W-1:0] bv[4] = '{-8'sd128, -8'sd128, 8'sd127, 8'sd127};
        int lat;
        logic [2*W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i]);
            wait_out(lat);
            e = pop_exp();
            total++;
            if (lat !== N || dout !== e)
                $display("FAIL extreme_%0d: lat=%0d dout=%h required lat=%0d dout=%h", i, lat, dout, N, e);
            else passed++;
            drain();
        end
    endtask

    task automatic test_zero();
        logic signed [W-1:0] av[4] = '{8'sd0, -8'sd7, -8'sd128, 8'sd0};
        logic signed [W-1:0] bv[4] = '{-8'sd7, 8'sd0, 8'sd0, 8'sd0};
        int lat;
        logic [2*W-1:0] e;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i]);
            wait_out(lat);
            e = pop_exp();
            total++;
            if (lat !== N || dout !== e)
                $display("FAIL zero_%0d: lat=%0d dout=%h required lat=%0d dout=%h", i, lat, dout, N, e);
            else passed++;
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*W-1:0] e;
        issue(8'sd11, -8'sd9);
        wait_out(lat);
        e = pop_exp();
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, dout} !== {1'b1, 1'b0, e})
                $display("FAIL bp_hold_%0d: vld/rdy=%b%b dout=%h required 10 %h", i, out_valid, in_ready, dout, e);
            else passed++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        din1 = 8'sd6;
        din2 = 8'sd7;
        push_exp(8'sd6, 8'sd7);
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_passthru_ready: got %b required 1", in_ready);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({out_valid, busy} !== 2'b01) $display("FAIL bp_reload: vld/busy=%b required 01", {out_valid, busy});
        else passed++;
        wait_out(lat);
        e = pop_exp();
        total++;
        if (lat !== N || dout !== e)
            $display("FAIL bp_second: lat=%0d dout=%h required lat=%0d dout=%h", lat, dout, N, e);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] e;
        logic spurious;
        issue(-8'sd100, 8'sd77);
        e = exp_q.pop_back();
`ifdef SEQ_MULT_SAT_EN
        void'(sat_q.pop_back());
`endif
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy, dout} !== '0)
            $display("FAIL midreset_async: rdy/vld/busy=%b%b%b dout=%h required 000 0000 (lost %h)",
                     in_ready, out_valid, busy, dout, e);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL midreset_ready: got %b required 1", in_ready);
        else passed++;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || busy) spurious = 1'b1;
        end
        total++;
        if (spurious !== 1'b0) $display("FAIL midreset_spurious: got %b required 0", spurious);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int stall;
        logic [2*W-1:0] e;
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom));
            wait_out(lat);
            e = pop_exp();
            total++;
            if (lat !== N || dout !== e)
                $display("FAIL rand_%0d: lat=%0d dout=%h required lat=%0d dout=%h", i, lat, dout, N, e);
            else passed++;
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            drain();
        end
    endtask

`ifdef SEQ_MULT_SAT_EN
    task automatic test_sat();
        logic signed [W-1:0] av[4] = '{8'sd100, 8'sd16, -8'sd100, -8'sd17};
        logic signed [W-1:0] bv[4] = '{8'sd100, 8'sd3, 8'sd100, 8'sd3};
        int lat;
        logic [W:0] e;
        sat_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i]);
            wait_out(lat);
            e = sat_q.pop_front();
            void'(pop_exp());
            total++;
            if ({sat, dout_q} !== e)
                $display("FAIL sat_%0d: sat=%b q=%h required sat=%b q=%h", i, sat, dout_q, e[W], e[W-1:0]);
            else passed++;
            drain();
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_MULT_SAT_EN
        test_sat();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
